// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and data bundle between the display-select stage and the BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int NBITS   = 22,
  parameter int NDIGITS = 7
);
  logic                   Start;
  logic [NBITS-1:0]       BinIn;
  logic [4*NDIGITS-1:0]   BcdOut;
  logic                   Busy;
  logic                   Done;
  logic                   Overflow;

  modport master (
    output Start, BinIn,
    input  BcdOut, Busy, Done, Overflow
  );

  modport slave (
    input  Start, BinIn,
    output BcdOut, Busy, Done, Overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with a held result register so the displays never see partial digits.
module bin_to_bcd_seq #(
  parameter int NBITS   = 22,
  parameter int NDIGITS = 7
) (
  input  logic             Clk,
  input  logic             Reset,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int BW = 4 * NDIGITS;
  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t           state_q;
  logic [NBITS-1:0] shift_q;
  logic [BW-1:0]    scratch_q;
  logic [CW-1:0]    cnt_q;
  logic             sticky_q;
  logic [BW-1:0]    bcd_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic [BW-1:0]    adj_d;
  logic [BW-1:0]    scratch_d;
  logic [NBITS-1:0] shift_d;
  logic             carry_d;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  // Adjust every digit in parallel, then shift {scratch, shift} left by one.
  always_comb begin
    adj_d = scratch_q;
    for (int k = 0; k < NDIGITS; k++) begin
      adj_d[4*k +: 4] = add3(scratch_q[4*k +: 4]);
    end
    {carry_d, scratch_d, shift_d} = {adj_d, shift_q, 1'b0};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.Start) begin
            shift_q   <= bus.BinIn;
            scratch_q <= '0;
            sticky_q  <= 1'b0;
            cnt_q     <= CW'(NBITS);
            busy_q    <= 1'b1;
            state_q   <= CONV;
          end
        end
        CONV: begin
          scratch_q <= scratch_d;
          shift_q   <= shift_d;
          cnt_q     <= cnt_q - CW'(1);
          sticky_q  <= sticky_q | carry_d;
          // Last bit: publish result and the overflow including this cycle's carry.
          if (cnt_q == CW'(1)) begin
            bcd_q   <= scratch_d;
            ovf_q   <= sticky_q | carry_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.BcdOut   = bcd_q;
  assign bus.Overflow = ovf_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;

endmodule
